// File: rtl/add_pipe.sv
// add_pipe: WIDTH-bit add with carry-in, resolved one SEG_W segment per stage behind valid/ready.
// Optional ADD_PIPE_SUB_EN adds i_sub, turning the operation into A - B - i_carry.
module add_pipe #(
    parameter int WIDTH = 48,
    parameter int SEG_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data_one,
    input  logic [WIDTH-1:0] i_data_two,
    input  logic             i_carry,
`ifdef ADD_PIPE_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry
);
    localparam int STAGES = WIDTH / SEG_W;

    if ((WIDTH % SEG_W) != 0 || WIDTH < SEG_W) begin : g_bad_width
        $error("add_pipe: WIDTH must be a non-zero integer multiple of SEG_W");
    end

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef ADD_PIPE_SUB_EN
    // B is inverted once on entry, so each operation carries its mode in its own operand bits.
    assign b_eff   = i_sub ? ~i_data_two : i_data_two;
    assign cin_eff = i_carry ^ i_sub;
`else
    assign b_eff   = i_data_two;
    assign cin_eff = i_carry;
`endif

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] cry;
    logic [WIDTH-1:0]  res [STAGES];
    logic [WIDTH-1:0]  opa [STAGES];
    logic [WIDTH-1:0]  opb [STAGES];
    logic [SEG_W:0]    sum [STAGES];

    // A stage advances unless it and every stage downstream of it is full and the sink stalls.
    always_comb begin : p_adv
        logic full_above;
        full_above = 1'b1;
        adv        = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_above = full_above & v[k];
            adv[k]     = i_ready | ~full_above;
        end
    end

    always_comb begin
        sum[0] = {1'b0, i_data_one[SEG_W-1:0]} + {1'b0, b_eff[SEG_W-1:0]}
               + {{SEG_W{1'b0}}, cin_eff};
        for (int k = 1; k < STAGES; k++) begin
            sum[k] = {1'b0, opa[k-1][k*SEG_W +: SEG_W]} + {1'b0, opb[k-1][k*SEG_W +: SEG_W]}
                   + {{SEG_W{1'b0}}, cry[k-1]};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v   <= '0;
            cry <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res[k] <= '0;
                opa[k] <= '0;
                opb[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                v[0] <= i_valid;
                if (i_valid) begin
                    res[0]            <= '0;
                    res[0][SEG_W-1:0] <= sum[0][SEG_W-1:0];
                    cry[0]            <= sum[0][SEG_W];
                    opa[0]            <= i_data_one;
                    opb[0]            <= b_eff;
                end
            end
            // Data registers only load behind a valid entry; empty stages keep stale contents.
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        res[k]                   <= res[k-1];
                        res[k][k*SEG_W +: SEG_W] <= sum[k][SEG_W-1:0];
                        cry[k]                   <= sum[k][SEG_W];
                        opa[k]                   <= opa[k-1];
                        opb[k]                   <= opb[k-1];
                    end
                end
            end
        end
    end

    assign o_ready = adv[0];
    assign o_valid = v[STAGES-1];
    assign o_data  = res[STAGES-1];
    assign o_carry = cry[STAGES-1];

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed vectors plus a short random stream against a 49-bit reference sum.
// Build with +define+ADD_PIPE_SUB_EN to also exercise the subtract mode.
module tb_add_pipe;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [47:0] i_data_one;
    logic [47:0] i_data_two;
    logic        i_carry;
`ifdef ADD_PIPE_SUB_EN
    logic        i_sub;
`endif
    logic        o_valid;
    logic        i_ready;
    logic [47:0] o_data;
    logic        o_carry;

    add_pipe #(.WIDTH(48), .SEG_W(16)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data_one (i_data_one),
        .i_data_two (i_data_two),
        .i_carry    (i_carry),
`ifdef ADD_PIPE_SUB_EN
        .i_sub      (i_sub),
`endif
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_carry    (o_carry)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [47:0] data;
        logic        carry;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk   = 0;
    int          n_err   = 0;
    int          n_cons  = 0;
    int          cyc     = 0;
    bit          chk_lat = 1'b0;
    bit          hold_prev = 1'b0;
    logic [47:0] prev_data;
    logic        prev_carry;
    logic [47:0] nxt_data;
    logic        nxt_carry;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [48:0] model(logic [47:0] a, logic [47:0] b, logic cin, logic sub);
        logic [48:0] d;
        if (sub) begin
            d = {1'b0, a} - {1'b0, b} - {48'd0, cin};
            return {~d[48], d[47:0]};
        end
        return {1'b0, a} + {1'b0, b} + {48'd0, cin};
    endfunction

    // Entered at a negedge; samples just before the next rising edge, then returns at the following negedge.
    task automatic step();
        exp_t e;
        #4;
        if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data", 64'(o_data), 64'(e.data));
                chk("carry", 64'(o_carry), 64'(e.carry));
                if (chk_lat) chk("latency", 64'(cyc - e.acc), 64'd3);
                n_cons++;
            end
        end
        if (o_valid && !i_ready && hold_prev) begin
            chk("hold_data", 64'(o_data), 64'(prev_data));
            chk("hold_carry", 64'(o_carry), 64'(prev_carry));
        end
        hold_prev  = o_valid && !i_ready;
        prev_data  = o_data;
        prev_carry = o_carry;
        if (i_valid && o_ready) exp_q.push_back('{nxt_data, nxt_carry, cyc});
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic drive(logic [47:0] a, logic [47:0] b, logic cin, logic sub,
                         logic [47:0] ed, logic ec);
        i_valid    = 1'b1;
        i_data_one = a;
        i_data_two = b;
        i_carry    = cin;
`ifdef ADD_PIPE_SUB_EN
        i_sub      = sub;
`else
        if (sub) $display("note: subtract vector issued on add-only build");
`endif
        nxt_data   = ed;
        nxt_carry  = ec;
        chk("accept_ready", 64'(o_ready), 64'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int          base;
        logic [47:0] ra, rb;
        logic        rc, rs;
        logic [48:0] m;

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_data_one = '0; i_data_two = '0; i_carry = 1'b0;
`ifdef ADD_PIPE_SUB_EN
        i_sub = 1'b0;
`endif
        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_carry", 64'(o_carry), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("rst_ready", 64'(o_ready), 64'd1);
        @(negedge i_clk);

        // single op, carry across segment 0 -> 1
        chk_lat = 1'b1;
        base = n_cons;
        drive(48'h0000_0000_FFFF, 48'h1, 1'b0, 1'b0, 48'h0000_0001_0000, 1'b0);
        i_valid = 1'b0;
        repeat (5) step();
        chk("t1_count", 64'(n_cons - base), 64'd1);

        // carry ripples through every segment
        base = n_cons;
        drive(48'hFFFF_FFFF_FFFF, 48'h0, 1'b1, 1'b0, 48'h0, 1'b1);
        drive(48'h0000_FFFF_0000, 48'h0000_0001_0000, 1'b0, 1'b0, 48'h0001_0000_0000, 1'b0);
        drive(48'h0000_FFFF_FFFF, 48'h0, 1'b1, 1'b0, 48'h0001_0000_0000, 1'b0);
        drive(48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b1, 1'b0, 48'h2345_6789_ABCE, 1'b0);
        i_valid = 1'b0;
        repeat (5) step();
        chk("ripple_count", 64'(n_cons - base), 64'd4);

        // back-to-back random stream
        base = n_cons;
        for (int i = 0; i < 10; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom_range(0, 1));
`ifdef ADD_PIPE_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            m = model(ra, rb, rc, rs);
            drive(ra, rb, rc, rs, m[47:0], m[48]);
        end
        i_valid = 1'b0;
        repeat (5) step();
        chk("stream_count", 64'(n_cons - base), 64'd10);

        // backpressure: fill, stall, then drain in a burst
        chk_lat = 1'b0;
        i_ready = 1'b0;
        drive(48'h1, 48'h2, 1'b0, 1'b0, 48'h3, 1'b0);
        drive(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0, 48'hFFFF_FFFF_FFFF, 1'b1);
        drive(48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 1'b0, 48'h0, 1'b1);
        i_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 64'(o_ready), 64'd0);
            chk("bp_valid", 64'(o_valid), 64'd1);
            step();
        end
        i_ready = 1'b1;
        base = n_cons;
        repeat (3) step();
        chk("bp_burst", 64'(n_cons - base), 64'd3);
        repeat (2) step();
        chk("bp_after", 64'(n_cons - base), 64'd3);

        // asynchronous reset while two ops are in flight
        chk_lat = 1'b1;
        drive(48'd10, 48'd20, 1'b0, 1'b0, 48'd30, 1'b0);
        drive(48'd100, 48'd200, 1'b0, 1'b0, 48'd300, 1'b0);
        i_valid = 1'b0;
        base = n_cons;
        step();
        chk("mid_valid_pre", 64'(o_valid), 64'd1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_data", 64'(o_data), 64'd0);
        exp_q.delete();
        hold_prev = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            chk("mid_no_old", 64'(o_valid), 64'd0);
            step();
        end
        chk("mid_count", 64'(n_cons - base), 64'd0);

`ifdef ADD_PIPE_SUB_EN
        base = n_cons;
        drive(48'd5, 48'd7, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFE, 1'b0);
        drive(48'd7, 48'd5, 1'b0, 1'b1, 48'd2, 1'b1);
        drive(48'd7, 48'd5, 1'b0, 1'b0, 48'd12, 1'b0);
        i_valid = 1'b0;
        repeat (5) step();
        chk("sub_count", 64'(n_cons - base), 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
